// File: rtl/griffin_round_controller_if.sv
// Handshake bundle between the Griffin round controller and its environment
// (host, nonlinear unit, linear unit, round-constant ROM).
interface griffin_round_controller_if #(
    parameter int unsigned N_BITS     = 254,
    parameter int unsigned STATE_SIZE = 3,
    parameter int unsigned RC_ADDR_W  = 4
);
    logic                                   start;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      in_state;
    logic                                   busy;
    logic                                   done;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      out_state;
    logic                                   nl_enable;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      nl_in_state;
    logic                                   nl_done;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      nl_out_state;
    logic                                   lin_start;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      lin_in_state;
    logic                                   lin_done;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      lin_out_state;
    logic [RC_ADDR_W-1:0]                   rc_addr;
    logic [STATE_SIZE-1:0][N_BITS-1:0]      rc_value;

    // master: the controller; slave: host plus the units it sequences
    modport master (
        input  start, in_state, nl_done, nl_out_state, lin_done, lin_out_state, rc_value,
        output busy, done, out_state, nl_enable, nl_in_state, lin_start, lin_in_state, rc_addr
    );
    modport slave (
        output start, in_state, nl_done, nl_out_state, lin_done, lin_out_state, rc_value,
        input  busy, done, out_state, nl_enable, nl_in_state, lin_start, lin_in_state, rc_addr
    );
endinterface

// File: rtl/griffin_round_controller.sv
// Griffin permutation sequencer: owns the state register, drives the nonlinear and
// linear units through their handshakes and performs the round-constant addition.
module griffin_round_controller #(
    parameter int unsigned       N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int unsigned       STATE_SIZE    = 3,
    parameter int unsigned       NUM_ROUNDS    = 14,
    parameter int unsigned       RC_ADDR_W     = 4
) (
    input logic                         clk,
    input logic                         reset,
    griffin_round_controller_if.master  bus
);
    localparam int unsigned CNT_W =
        ($clog2(NUM_ROUNDS) > RC_ADDR_W) ? $clog2(NUM_ROUNDS) : RC_ADDR_W;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    typedef logic [STATE_SIZE-1:0][N_BITS-1:0] word_vec_t;
    typedef enum logic [2:0] {S_IDLE, S_PRE_LIN, S_NL, S_LIN, S_ARC, S_DONE} state_e;

    state_e                          state, state_nx;
    word_vec_t                       st, st_nx, out_q, out_nx, arc_sum;
    logic [STATE_SIZE-1:0][N_BITS:0] arc_raw;
    logic [CNT_W-1:0]                round, round_nx;
    logic busy_q, done_q, nl_en_q, lin_start_q;
    logic busy_nx, done_nx, nl_en_nx, lin_start_nx;

    // Modular add of the round constants, one conditional subtract per word
    always_comb begin
        for (int i = 0; i < STATE_SIZE; i++) begin
            arc_raw[i] = {1'b0, st[i]} + {1'b0, bus.rc_value[i]};
            arc_sum[i] = (arc_raw[i] >= {1'b0, PRIME_MODULUS})
                       ? N_BITS'(arc_raw[i] - {1'b0, PRIME_MODULUS})
                       : N_BITS'(arc_raw[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.start)    state_nx = S_PRE_LIN;
            S_PRE_LIN: if (bus.lin_done) state_nx = S_NL;
            S_NL:      if (bus.nl_done)  state_nx = S_LIN;
            S_LIN:     if (bus.lin_done) state_nx = (round < LAST_ROUND) ? S_ARC : S_DONE;
            S_ARC:                       state_nx = S_NL;
            S_DONE:                      state_nx = S_IDLE;
            default:                     state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        st_nx        = st;
        round_nx     = round;
        out_nx       = out_q;
        busy_nx      = (state_nx != S_IDLE);
        done_nx      = (state_nx == S_DONE);
        nl_en_nx     = (state_nx == S_NL);
        lin_start_nx = ((state_nx == S_PRE_LIN) || (state_nx == S_LIN)) && (state_nx != state);
        case (state)
            S_IDLE: if (bus.start) begin
                st_nx    = bus.in_state;
                round_nx = '0;
            end
            S_PRE_LIN, S_LIN: if (bus.lin_done) st_nx = bus.lin_out_state;
            S_NL:             if (bus.nl_done)  st_nx = bus.nl_out_state;
            S_ARC: begin
                st_nx    = arc_sum;
                round_nx = round + CNT_W'(1);
            end
            default: ;
        endcase
        if (state_nx == S_DONE) out_nx = st_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= '0;
            round       <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nl_en_q     <= 1'b0;
            lin_start_q <= 1'b0;
        end else begin
            st          <= st_nx;
            round       <= round_nx;
            out_q       <= out_nx;
            busy_q      <= busy_nx;
            done_q      <= done_nx;
            nl_en_q     <= nl_en_nx;
            lin_start_q <= lin_start_nx;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.out_state    = out_q;
    assign bus.nl_enable    = nl_en_q;
    assign bus.lin_start    = lin_start_q;
    assign bus.nl_in_state  = st;
    assign bus.lin_in_state = st;
    assign bus.rc_addr      = RC_ADDR_W'(round);
endmodule

// File: tb/tb_griffin_round_controller.sv
// Bench for griffin_round_controller with identity nonlinear stub (4 cycles),
// +1 mod p linear stub (2 cycles) and rc_value = rc_addr + 1.
module tb_griffin_round_controller;
    localparam int unsigned N_BITS     = 254;
    localparam int unsigned STATE_SIZE = 3;
    localparam int unsigned NR         = 3;
    localparam int unsigned RC_ADDR_W  = 4;
    localparam logic [N_BITS-1:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int T_LIN = 2;
    localparam int T_NL  = 4;
    localparam int EXP_LAT = 1 + (NR + 1) * T_LIN + NR * T_NL + (NR - 1);

    typedef logic [STATE_SIZE-1:0][N_BITS-1:0] st_t;
    typedef struct { string name; st_t vin; st_t exp; } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   nl_cnt = 0;
    logic lin_arm = 1'b0;

    always #5 clk = ~clk;

    griffin_round_controller_if #(.N_BITS(N_BITS), .STATE_SIZE(STATE_SIZE), .RC_ADDR_W(RC_ADDR_W)) bus ();

    griffin_round_controller #(
        .N_BITS(N_BITS), .PRIME_MODULUS(P), .STATE_SIZE(STATE_SIZE),
        .NUM_ROUNDS(NR), .RC_ADDR_W(RC_ADDR_W)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [N_BITS-1:0] addm(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        logic [255:0] t;
        t = 256'(a) + 256'(b);
        return N_BITS'(t % 256'(P));
    endfunction

    // Reference: whole permutation as a plain sequence of field operations
    function automatic st_t model(input st_t x);
        st_t s;
        s = x;
        for (int i = 0; i < STATE_SIZE; i++) s[i] = addm(s[i], N_BITS'(1));
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < STATE_SIZE; i++) s[i] = addm(s[i], N_BITS'(1));
            if (r < NR - 1)
                for (int i = 0; i < STATE_SIZE; i++) s[i] = addm(s[i], N_BITS'(r + 1));
        end
        return s;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < STATE_SIZE; i++) begin
            logic [255:0] r;
            r = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            r[255:254] = 2'b00;
            s[i] = N_BITS'(r % 256'(P));
        end
        return s;
    endfunction

    function automatic st_t splat(input logic [N_BITS-1:0] w);
        st_t s;
        for (int i = 0; i < STATE_SIZE; i++) s[i] = w;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Stub units react on the falling edge so their outputs are stable at the rising edge
    always @(negedge clk) begin
        if (!reset) begin
            nl_cnt       = 0;
            lin_arm      = 1'b0;
            bus.nl_done  = 1'b0;
            bus.lin_done = 1'b0;
        end else begin
            bus.lin_done = 1'b0;
            if (bus.lin_start) lin_arm = 1'b1;
            else if (lin_arm) begin
                bus.lin_done = 1'b1;
                lin_arm      = 1'b0;
            end
            for (int i = 0; i < STATE_SIZE; i++)
                bus.lin_out_state[i] = addm(bus.lin_in_state[i], N_BITS'(1));
            bus.nl_done = 1'b0;
            if (bus.nl_enable) begin
                nl_cnt++;
                if (nl_cnt == T_NL) begin
                    bus.nl_done = 1'b1;
                    nl_cnt      = 0;
                end
            end else nl_cnt = 0;
            bus.nl_out_state = bus.nl_in_state;
        end
    end

    always_comb begin
        for (int i = 0; i < STATE_SIZE; i++)
            bus.rc_value[i] = N_BITS'(bus.rc_addr) + N_BITS'(1);
    end

    task automatic run_perm(input string nm, input st_t vin, input st_t exp, input bit hold);
        int   k, lin_pulses, nl_rises, nl_falls;
        bit   busy_ok, pulse_ok;
        logic prev_ls, prev_nl;
        int   rc_q[$];
        @(negedge clk);
        bus.in_state = vin;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        k = 1; lin_pulses = 0; nl_rises = 0; nl_falls = 0;
        busy_ok = 1'b1; pulse_ok = 1'b1; prev_ls = 1'b0; prev_nl = 1'b0;
        while (bus.done !== 1'b1 && k < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.lin_start === 1'b1) begin
                if (prev_ls) pulse_ok = 1'b0;
                else         lin_pulses++;
            end
            if (bus.nl_enable === 1'b1 && !prev_nl) nl_rises++;
            if (bus.nl_enable === 1'b0 && prev_nl)  nl_falls++;
            // lin_done seen here belongs to the previous cycle; a non-NL successor is ARC
            if (bus.lin_done === 1'b1 && bus.nl_enable === 1'b0) rc_q.push_back(int'(bus.rc_addr));
            prev_ls = bus.lin_start;
            prev_nl = bus.nl_enable;
            if (hold) bus.in_state = rand_state();
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " done_latency"}, 768'(k), 768'(EXP_LAT));
        chk({nm, " out_state"}, 768'(bus.out_state), 768'(exp));
        chk({nm, " busy_span"}, 768'(busy_ok && bus.busy === 1'b1), 768'(1));
        chk({nm, " lin_start_pulses"}, 768'(lin_pulses), 768'(NR + 1));
        chk({nm, " lin_start_width"}, 768'(pulse_ok), 768'(1));
        chk({nm, " nl_enable_rises"}, 768'(nl_rises), 768'(NR));
        chk({nm, " nl_enable_falls"}, 768'(nl_falls), 768'(NR));
        chk({nm, " rc_arc_count"}, 768'(rc_q.size()), 768'(NR - 1));
        for (int j = 0; j < rc_q.size(); j++)
            chk({nm, " rc_addr_in_arc"}, 768'(rc_q[j]), 768'(j));
        @(posedge clk); #1;
        chk({nm, " idle_after_done"}, 768'({bus.busy, bus.done}), 768'(0));
    endtask

    initial begin
        vec_t vecs[5];
        st_t  v;
        int   rises, k;
        logic prev;

        vecs[0] = '{name: "all_zero",  vin: '0,              exp: splat(N_BITS'(7))};
        vecs[1] = '{name: "wrap_p_m3", vin: splat(P - 254'd3), exp: splat(N_BITS'(4))};
        vecs[2] = '{name: "wrap_to_0", vin: splat(P - 254'd7), exp: '0};
        vecs[3] = '{name: "mixed",     vin: {P - 254'd8, 254'd5, P - 254'd1},
                    exp: {P - 254'd1, 254'd12, 254'd6}};
        vecs[4] = '{name: "small",     vin: {254'd1, 254'd2, 254'd3},
                    exp: {254'd8, 254'd9, 254'd10}};

        reset = 1'b0;
        bus.start = 1'b0;
        bus.in_state = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 768'(bus.busy), 768'(0));
        chk("rst done", 768'(bus.done), 768'(0));
        chk("rst nl_enable", 768'(bus.nl_enable), 768'(0));
        chk("rst lin_start", 768'(bus.lin_start), 768'(0));
        chk("rst rc_addr", 768'(bus.rc_addr), 768'(0));
        chk("rst out_state", 768'(bus.out_state), 768'(0));
        chk("rst nl_in_state", 768'(bus.nl_in_state), 768'(0));
        chk("rst lin_in_state", 768'(bus.lin_in_state), 768'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_perm(vecs[i].name, vecs[i].vin, vecs[i].exp, 1'b0);

        for (int i = 0; i < 6; i++) begin
            v = rand_state();
            run_perm("random", v, model(v), 1'b0);
        end

        // start held high and in_state scrambled while busy
        v = rand_state();
        run_perm("held_start", v, model(v), 1'b1);
        v = rand_state();
        run_perm("after_held", v, model(v), 1'b0);

        // reset during the second NL phase
        @(negedge clk);
        bus.in_state = rand_state();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rises = 0; k = 0; prev = 1'b0;
        while (rises < 2 && k < 100) begin
            if (bus.nl_enable === 1'b1 && !prev) rises++;
            prev = bus.nl_enable;
            if (rises < 2) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("rst_mid second_nl_reached", 768'(rises), 768'(2));
        reset = 1'b0;
        #1;
        chk("rst_mid busy", 768'(bus.busy), 768'(0));
        chk("rst_mid nl_enable", 768'(bus.nl_enable), 768'(0));
        chk("rst_mid out_state", 768'(bus.out_state), 768'(0));
        chk("rst_mid rc_addr", 768'(bus.rc_addr), 768'(0));
        chk("rst_mid nl_in_state", 768'(bus.nl_in_state), 768'(0));
        @(negedge clk);
        reset = 1'b1;
        v = rand_state();
        run_perm("after_reset", v, model(v), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
